// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I fetch front end.
package rv32i_pkg;

  localparam int unsigned QUEUE_DEPTH = 2;
  localparam int unsigned QCNT_W      = 2;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_ZERO       = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] word_index(input logic [31:0] pc);
    return {2'b00, pc[31:2]};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {instr, pc} pairs; clear wins over push/pop.
module fetch_queue
  import rv32i_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  fetch_entry_t      push_data,
  input  logic              pop,
  input  logic              clear,
  output logic              full,
  output logic              empty,
  output fetch_entry_t      head,
  output logic [QCNT_W-1:0] count
);

  fetch_entry_t        r_mem [QUEUE_DEPTH];
  logic                r_rd_ptr;
  logic                r_wr_ptr;
  logic [QCNT_W-1:0]   r_count;

  logic w_do_pop;
  logic w_do_push;

  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != QCNT_W'(QUEUE_DEPTH)) || w_do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (clear) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + QCNT_W'(w_do_push) - QCNT_W'(w_do_pop);
    end
  end

  assign full  = (r_count == QCNT_W'(QUEUE_DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// RV32I instruction fetch: PC, BOOT/RUN/HALT control, fault and zero-word
// halting, and a 2-entry queue feeding decode over valid/ready.
module instruction_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        halted,
  output logic        fetch_fault
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic         r_fault;
  logic         w_fault_nxt;

  logic              w_push;
  logic              w_clear;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_enq_ok;
  logic              w_bad_pc;
  logic              w_zero_word;
  logic [QCNT_W-1:0] w_count;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_data;

  assign w_pop       = !w_empty && id_ready;
  assign w_enq_ok    = (w_count < QCNT_W'(QUEUE_DEPTH)) || (w_full && w_pop);
  assign w_bad_pc    = (r_pc[1:0] != 2'b00) || (word_index(r_pc) >= 32'(IMEM_DEPTH));
  assign w_zero_word = (imem_rd == INSTR_ZERO);
  assign w_push_data = '{instr: imem_rd, pc: r_pc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  // Priority: redirect, bad PC, zero word, normal enqueue.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_fault_nxt = r_fault;
    w_push      = 1'b0;
    w_clear     = 1'b0;

    if (redirect_valid) begin
      w_clear  = 1'b1;
      w_pc_nxt = redirect_pc;
      if (redirect_pc[1:0] == 2'b00) begin
        w_state_nxt = ST_RUN;
        w_fault_nxt = 1'b0;
      end else begin
        w_state_nxt = ST_HALT;
        w_fault_nxt = 1'b1;
      end
    end else begin
      case (r_state)
        ST_BOOT: begin
          w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (w_bad_pc) begin
            w_state_nxt = ST_HALT;
            w_fault_nxt = 1'b1;
          end else if (w_zero_word) begin
            w_state_nxt = ST_HALT;
          end else if (w_enq_ok) begin
            w_push   = 1'b1;
            w_pc_nxt = pc_plus4(r_pc);
          end
        end
        ST_HALT: begin
          w_state_nxt = ST_HALT;
        end
        default: begin
          w_state_nxt = ST_HALT;
          w_fault_nxt = 1'b1;
        end
      endcase
    end
  end

  fetch_queue u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .clear     (w_clear),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head),
    .count     (w_count)
  );

  // Payload reads as zero whenever nothing is presented, including in reset.
  assign id_valid    = !w_empty;
  assign id_instr    = w_empty ? 32'h0 : w_head.instr;
  assign id_pc       = w_empty ? 32'h0 : w_head.pc;
  assign id_pc_plus4 = w_empty ? 32'h0 : pc_plus4(w_head.pc);

  assign imem_addr   = word_index(r_pc);
  assign halted      = (r_state == ST_HALT);
  assign fetch_fault = r_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_instruction_fetch;

  localparam int unsigned DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        halted;
  logic        fetch_fault;

  logic [31:0] mem [DEPTH];

  int n_checks;
  int n_err;

  instruction_fetch #(.RESET_PC(32'h0), .IMEM_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .halted         (halted),
    .fetch_fault    (fetch_fault)
  );

  assign imem_rd = (imem_addr < 32'(DEPTH)) ? mem[imem_addr[9:0]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a program counter, a FIFO of fetched entries and run flags.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_run;
  bit          m_fault;

  task automatic model_reset();
    mq.delete();
    m_pc    = 32'h0;
    m_boot  = 1'b1;
    m_run   = 1'b0;
    m_fault = 1'b0;
  endtask

  task automatic model_step();
    bit   pop;
    ent_t e;
    pop = (mq.size() > 0) && id_ready;
    if (redirect_valid) begin
      mq.delete();
      m_pc    = redirect_pc;
      m_boot  = 1'b0;
      m_run   = (redirect_pc[1:0] == 2'b00);
      m_fault = !m_run;
    end else begin
      if (pop) mq.delete(0);
      if (m_boot) begin
        m_boot = 1'b0;
        m_run  = 1'b1;
      end else if (m_run) begin
        if (m_pc[1:0] != 2'b00 || (m_pc >> 2) >= 32'(DEPTH)) begin
          m_run   = 1'b0;
          m_fault = 1'b1;
        end else if (mem[m_pc[11:2]] == 32'h0) begin
          m_run = 1'b0;
        end else if (mq.size() < 2) begin
          e.instr = mem[m_pc[11:2]];
          e.pc    = m_pc;
          mq.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_valid", 32'(id_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("m_pc", id_pc, mq[0].pc);
      chk("m_instr", id_instr, mq[0].instr);
      chk("m_pc4", id_pc_plus4, mq[0].pc + 32'd4);
    end
    chk("m_halted", 32'(halted), 32'(!m_boot && !m_run));
    chk("m_fault", 32'(fetch_fault), 32'(m_fault));
    chk("m_addr", imem_addr, m_pc >> 2);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_program();
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h0;
    mem[0] = 32'hFFC4A303;
    mem[1] = 32'h00832383;
    mem[2] = 32'h0064A423;
    mem[3] = 32'h00B62423;
    mem[4] = 32'h0062E233;
    mem[5] = 32'h00B62423;
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_halted;
    logic        e_fault;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic rdy, input logic rv, input logic [31:0] rpc,
                         input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                         input logic eh, input logic ef, input logic [31:0] ea);
    vec_t v;
    v.ready = rdy; v.redir = rv; v.rpc = rpc;
    v.e_valid = ev; v.e_pc = epc; v.e_instr = ein;
    v.e_halted = eh; v.e_fault = ef; v.e_addr = ea;
    tbl.push_back(v);
  endtask

  initial begin
    n_checks = 0;
    n_err = 0;
    rst = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    load_program();
    #1;
    chk("rst_valid", 32'(id_valid), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);

    // Streaming, halt on zero word, misaligned/aligned/out-of-range redirects.
    add_vec(1, 0, 32'h0,    0, 32'h00, 32'h0,        0, 0, 32'h0);
    add_vec(1, 0, 32'h0,    1, 32'h00, 32'hFFC4A303, 0, 0, 32'h1);
    add_vec(1, 0, 32'h0,    1, 32'h04, 32'h00832383, 0, 0, 32'h2);
    add_vec(1, 0, 32'h0,    1, 32'h08, 32'h0064A423, 0, 0, 32'h3);
    add_vec(1, 0, 32'h0,    1, 32'h0C, 32'h00B62423, 0, 0, 32'h4);
    add_vec(1, 0, 32'h0,    1, 32'h10, 32'h0062E233, 0, 0, 32'h5);
    add_vec(1, 0, 32'h0,    1, 32'h14, 32'h00B62423, 0, 0, 32'h6);
    add_vec(1, 0, 32'h0,    0, 32'h00, 32'h0,        1, 0, 32'h6);
    add_vec(1, 0, 32'h0,    0, 32'h00, 32'h0,        1, 0, 32'h6);
    add_vec(1, 1, 32'h6,    0, 32'h00, 32'h0,        1, 1, 32'h1);
    add_vec(1, 0, 32'h0,    0, 32'h00, 32'h0,        1, 1, 32'h1);
    add_vec(1, 1, 32'h0,    0, 32'h00, 32'h0,        0, 0, 32'h0);
    add_vec(1, 0, 32'h0,    1, 32'h00, 32'hFFC4A303, 0, 0, 32'h1);
    add_vec(1, 1, 32'h1000, 0, 32'h00, 32'h0,        0, 0, 32'h400);
    add_vec(1, 0, 32'h0,    0, 32'h00, 32'h0,        1, 1, 32'h400);
    add_vec(1, 0, 32'h0,    0, 32'h00, 32'h0,        1, 1, 32'h400);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      id_ready = tbl[i].ready;
      redirect_valid = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      step();
      chk($sformatf("v%0d_valid", i), 32'(id_valid), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(tbl[i].e_halted));
      chk($sformatf("v%0d_fault", i), 32'(fetch_fault), 32'(tbl[i].e_fault));
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
      if (tbl[i].e_valid) begin
        chk($sformatf("v%0d_pc", i), id_pc, tbl[i].e_pc);
        chk($sformatf("v%0d_instr", i), id_instr, tbl[i].e_instr);
        chk($sformatf("v%0d_pc4", i), id_pc_plus4, tbl[i].e_pc + 32'd4);
      end
    end
    redirect_valid = 1'b0;

    // Backpressure: queue fills with pcs 0,4, then drains with no bubble.
    id_ready = 1'b0;
    do_reset();
    repeat (4) step();
    chk("bp_valid", 32'(id_valid), 32'h1);
    chk("bp_head", id_pc, 32'h0);
    chk("bp_instr", id_instr, 32'hFFC4A303);
    chk("bp_stall", imem_addr, 32'h2);
    id_ready = 1'b1;
    step();
    chk("bp_rel1", id_pc, 32'h4);
    chk("bp_rel1_addr", imem_addr, 32'h3);
    step();
    chk("bp_rel2", id_pc, 32'h8);
    chk("bp_rel2_valid", 32'(id_valid), 32'h1);

    // Redirect to 0x10 while the queue is full.
    id_ready = 1'b0;
    do_reset();
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    id_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("rd_gap", 32'(id_valid), 32'h0);
    chk("rd_addr", imem_addr, 32'h4);
    step();
    chk("rd_valid", 32'(id_valid), 32'h1);
    chk("rd_instr", id_instr, 32'h0062E233);
    chk("rd_pc", id_pc, 32'h10);
    chk("rd_pc4", id_pc_plus4, 32'h14);

    // Asynchronous reset with a full queue, then boot sequence again.
    id_ready = 1'b0;
    do_reset();
    repeat (3) step();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("ar_valid", 32'(id_valid), 32'h0);
    chk("ar_instr", id_instr, 32'h0);
    chk("ar_pc", id_pc, 32'h0);
    chk("ar_pc4", id_pc_plus4, 32'h0);
    chk("ar_halted", 32'(halted), 32'h0);
    chk("ar_fault", 32'(fetch_fault), 32'h0);
    chk("ar_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    id_ready = 1'b1;
    step();
    chk("ar_boot_valid", 32'(id_valid), 32'h0);
    step();
    chk("ar_fetch_valid", 32'(id_valid), 32'h1);
    chk("ar_fetch_pc", id_pc, 32'h0);

    // Randomized run against the reference model.
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 31) == 0 || mem[i] == 32'h0) mem[i] = (i % 7 == 0) ? 32'h0 : 32'h13;
    end
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 9))
        0:       redirect_pc = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
        1:       redirect_pc = ($urandom | 32'h1000) & ~32'h3;
        2:       redirect_pc = 32'($urandom_range(1018, 1023)) << 2;
        default: redirect_pc = 32'($urandom_range(0, 1023)) << 2;
      endcase
      step();
      check_model();
    end
    redirect_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit for the pipelined RV32I core: the initiator side of the instruction-memory read interface. It owns the PC, presents word addresses to the instruction memory, and buffers returned instructions in a 2-entry queue. It hands `{instr, pc, pc+4}` to the decode stage over a valid/ready handshake, and handles branch/jump redirects, flushes and halt detection.

## Interface
- `RESET_PC`, 32'h0000_0000, byte address fetched first after reset
- `IMEM_DEPTH`, 1024, instruction memory depth in 32-bit words
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `imem_addr`  out  32  word index to instruction memory, `{2'b00, pc[31:2]}`
- `imem_rd`  in  32  instruction word; combinational read of `imem_addr`, same cycle
- `redirect_valid`  in  1  branch/jump/flush request, single-cycle pulse
- `redirect_pc`  in  32  redirect target, byte address
- `id_valid`  out  1  queue head valid toward decode
- `id_ready`  in  1  decode accepts head this cycle
- `id_instr`  out  32  head instruction
- `id_pc`  out  32  head PC
- `id_pc_plus4`  out  32  head PC + 4
- `halted`  out  1  fetch stopped (state HALT)
- `fetch_fault`  out  1  halt caused by misaligned or out-of-range PC

## Operation
- The FSM has three states:
  - BOOT: entered on reset. No fetch. Moves to RUN next cycle.
  - RUN: fetches one word per cycle when an enqueue is allowed.
  - HALT: no fetch. Leaves only on an aligned redirect.
- Enqueue is allowed in RUN when `count<2`, or when `count==2` with a pop in the same cycle. On enqueue, push `{imem_rd, pc}` and set `pc <= pc+4`. Otherwise hold `pc`.
- Pop occurs when `id_valid && id_ready`. The queue is a 2-entry FIFO and its head drives `id_*`. `id_pc_plus4` is computed from the head PC with mod-2^32 wrap.
- Priority, highest first: redirect, fault check, zero-word check, normal enqueue.
- Redirect in any state:
  - Queue is cleared (`count<=0`); any same-cycle pop is subsumed.
  - No enqueue that cycle; `pc <= redirect_pc`.
  - If `redirect_pc[1:0]==0`: state becomes RUN, `fetch_fault` clears.
  - If misaligned: state becomes HALT, `fetch_fault` is set, `pc` takes the target value.
- In RUN, if `pc[31:2] >= IMEM_DEPTH`: no enqueue, state becomes HALT, `fetch_fault` is set.
- In RUN, if `imem_rd == 32'h0000_0000` (end-of-program marker / illegal in RV32I): no enqueue, `pc` held, state becomes HALT, `fetch_fault` stays 0.
- In HALT, already-queued entries still drain to decode normally.
- `imem_addr` is driven from `pc` in every state.

## Timing
- Reset values while `rst==0`:
  - `pc = RESET_PC`, `count = 0`, state BOOT.
  - `id_valid = 0`, `id_instr = 0`, `id_pc = 0`, `id_pc_plus4 = 0`.
  - `halted = 0`, `fetch_fault = 0`, `imem_addr = RESET_PC>>2`.
- Reset assertion mid-operation clears everything asynchronously; queued instructions are lost.
- Startup: first rising edge after `rst` deassert is cycle 0 (BOOT). Cycle 1 fetches `RESET_PC`. Cycle 2 shows `id_valid=1` with that instruction.
- Fetch-to-decode latency is 1 cycle (registered queue). Sustained throughput is 1 instr/cycle when `id_ready=1`.
- Redirect asserted in cycle t: cycle t+1 fetches `redirect_pc`; `id_valid` is 0 in t+1; target instruction is presented in t+2.
- Backpressure: with `id_ready=0`, two fetches fill the queue and `pc` stalls. Releasing `id_ready` resumes enqueue in the same cycle as the pop, with no bubble.
- `halted` and `fetch_fault` are registered; they assert the cycle after the triggering condition.
- `id_*` is stable while `id_valid && !id_ready`, unless a redirect or reset occurs.

## Structure
- Shared header/package `rv32i_pkg`:
  - FSM state encodings BOOT/RUN/HALT.
  - `INSTR_ZERO = 32'h0000_0000`.
  - Default `RESET_PC`.
- Sub-module `fetch_queue`: 2-entry FIFO, 64-bit payload `{instr, pc}`.
  - Ports: `push`, `pop`, `clear`, `full`, `empty`, `head`, `count`.
  - `clear` overrides `push`/`pop`.
- Top level holds the PC register, FSM, and the fault/zero checks.

## Test plan
- Startup/streaming: memory words 0..5 = FFC4A303, 00832383, 0064A423, 00B62423, 0062E233, 00B62423; word 6 = 0; `id_ready=1`.
  - Expect six handshakes with `id_pc` 0,4,...,20 and matching `id_instr`.
  - Then `halted=1`, `fetch_fault=0`, `imem_addr` held at 6.
- Backpressure: `id_ready=0` from cycle 2.
  - Expect queue to hold pcs 0,4 and `imem_addr` to stall at 2.
  - Raise `id_ready` and expect pcs 0,4,8 in consecutive cycles with no gap.
- Redirect: pulse `redirect_valid` with `redirect_pc=0x10` while the queue holds 2 entries.
  - Expect `id_valid=0` next cycle, then `id_instr=0062E233`, `id_pc=0x10`.
- Misaligned redirect: `redirect_pc=0x6`.
  - Expect `halted=1`, `fetch_fault=1`, queue empty.
  - A later redirect to `0x0` resumes fetch with `fetch_fault=0`.
- Out of range: redirect to `0x1000` (word 1024).
  - Expect no enqueue, `halted=1`, `fetch_fault=1`.
- Reset mid-stream: drop `rst` while the queue is full.
  - Expect all outputs at reset values immediately.
  - After release, expect the BOOT-then-fetch sequence from `RESET_PC`.
